// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational-read
// instruction memory.
//   imem_addr  : fetch address (driven by the fetch stage, always word aligned)
//   imem_rdata : instruction word at imem_addr, valid in the same cycle
// Modports: master = fetch stage side, slave = memory side.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Owns the PC, drives the instruction-memory address, and registers the
// fetched word together with PC+4 for decode. Redirects (JR, J/JAL, taken
// branch) resolved in ID are applied here, as are stall/flush requests from
// the hazard unit.
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous, active-low reset
//   stall        : hold PC and IF/ID
//   flush        : load a bubble into IF/ID
//   br_taken     : conditional branch taken, target br_target
//   jump         : J/JAL, target jump_target
//   jumptoreg    : JR, target jr_target
//   imem         : instruction-memory bus (master side)
//   pc_f         : current fetch PC
//   instr_d      : IF/ID instruction word (all-zero for a bubble)
//   pcplus4_d    : IF/ID PC+4 (zero for a bubble)
//   valid_d      : IF/ID holds a real instruction
//   misalign     : one-cycle pulse when an accepted redirect target was not
//                  word aligned (the PC itself is always forced aligned)
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DELAY_SLOT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               br_taken,
  input  logic [31:0]        br_target,
  input  logic               jump,
  input  logic [31:0]        jump_target,
  input  logic               jumptoreg,
  input  logic [31:0]        jr_target,
  fetch_stage_if.master      imem,
  output logic [31:0]        pc_f,
  output logic [31:0]        instr_d,
  output logic [31:0]        pcplus4_d,
  output logic               valid_d,
  output logic               misalign
);

  logic [31:0] pcplus4_f;
  logic        redirect;
  logic [31:0] target;

  logic [31:0] pc_n;
  logic [31:0] instr_n;
  logic [31:0] pcplus4_n;
  logic        valid_n;
  logic        misalign_n;

  assign imem.imem_addr = pc_f;
  assign pcplus4_f      = pc_f + 32'd4;  // modulo 2^32, wrap is silent

  // A bubble in ID must never redirect, whatever its stale inputs say.
  assign redirect = valid_d & (jumptoreg | jump | br_taken);
  assign target   = jumptoreg ? jr_target :
                    jump      ? jump_target : br_target;

  always_comb begin
    pc_n       = pc_f;
    instr_n    = instr_d;
    pcplus4_n  = pcplus4_d;
    valid_n    = valid_d;
    misalign_n = 1'b0;

    if (stall) begin
      // Stall wins over redirect; ID re-presents it once unstalled.
      if (flush) begin
        instr_n   = 32'h0;
        pcplus4_n = 32'h0;
        valid_n   = 1'b0;
      end
    end else if (redirect) begin
      pc_n       = target & 32'hFFFF_FFFC;
      misalign_n = (target[1:0] != 2'b00);
      if (DELAY_SLOT == 0 || flush) begin
        instr_n   = 32'h0;
        pcplus4_n = 32'h0;
        valid_n   = 1'b0;
      end else begin
        instr_n   = imem.imem_rdata;
        pcplus4_n = pcplus4_f;
        valid_n   = 1'b1;
      end
    end else begin
      pc_n = pcplus4_f;
      if (flush) begin
        instr_n   = 32'h0;
        pcplus4_n = 32'h0;
        valid_n   = 1'b0;
      end else begin
        instr_n   = imem.imem_rdata;
        pcplus4_n = pcplus4_f;
        valid_n   = 1'b1;
      end
    end
  end

  // IF -> ID boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f      <= RESET_PC;
      instr_d   <= 32'h0;
      pcplus4_d <= 32'h0;
      valid_d   <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      pc_f      <= pc_n;
      instr_d   <= instr_n;
      pcplus4_d <= pcplus4_n;
      valid_d   <= valid_n;
      misalign  <= misalign_n;
    end
  end

endmodule
